mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_control_unit_alu_decode.sv | 41 ++++
 rtl/mc_control_unit.sv | 172 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Multicycle control unit shared definitions.
// State codes, opcode/funct constants and ALU operation codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MR  = 4'd3,
    S_MWB = 4'd4,
    S_MW  = 4'd5,
    S_EXR = 4'd6,
    S_WBR = 4'd7,
    S_BR  = 4'd8,
    S_JMP = 4'd9,
    S_EXI = 4'd10,
    S_WBI = 4'd11,
    S_ERR = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BRO = 2'b11;

endpackage

// File: rtl/mc_control_unit_alu_decode.sv
// ALU operation select for the multicycle controller.
// Maps state and latched instruction fields to alu_op.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_ok
);

  logic [2:0] fn_op;

  // R-type funct field to ALU code
  always_comb begin
    fn_op    = ALU_AND;
    funct_ok = 1'b1;
    unique case (1'b1)
      (funct == FN_ADD): fn_op = ALU_ADD;
      (funct == FN_SUB): fn_op = ALU_SUB;
      (funct == FN_AND): fn_op = ALU_AND;
      (funct == FN_OR):  fn_op = ALU_OR;
      (funct == FN_SLT): fn_op = ALU_SLT;
      default:           funct_ok = 1'b0;
    endcase
  end

  // per-state ALU operation, AND code when unused
  always_comb begin
    alu_op = ALU_AND;
    case (state)
      S_IF, S_ID, S_MA: alu_op = ALU_ADD;
      S_EXR, S_WBR:     alu_op = fn_op;
      S_EXI:            alu_op = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      S_BR:             alu_op = ALU_SUB;
      default:          alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM.
// Moore outputs from registered state; IF/BR enables gated by ready/zero.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic       ill_q;
  logic       ready;
  logic       funct_ok;

  logic mreq;
  logic mwe;
  logic irw;
  logic pcw;
  logic rgw;

  assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  mc_alu_decode u_alu_dec (
    .state    (state_q),
    .op       (op_q),
    .funct    (fn_q),
    .alu_op   (alu_op),
    .funct_ok (funct_ok)
  );

  // state, latched instruction fields and sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      op_q    <= '0;
      fn_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (state_d == S_ERR) ill_q <= 1'b1;
    end
  end

  // next state and control decode
  always_comb begin
    state_d    = state_q;
    mreq       = 1'b0;
    mwe        = 1'b0;
    irw        = 1'b0;
    pcw        = 1'b0;
    rgw        = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = 2'b00;
    unique case (state_q)
      S_IF: begin
        mreq      = 1'b1;
        alu_src_b = SRCB_4;
        if (ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = SRCB_BRO;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MA;
          (opcode == OP_RTYPE): state_d = S_EXR;
          (opcode == OP_BEQ):   state_d = S_BR;
          (opcode == OP_J):     state_d = S_JMP;
          (opcode == OP_ADDI),
          (opcode == OP_ORI):   state_d = S_EXI;
          default:              state_d = S_ERR;
        endcase
      end
      S_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        mreq = 1'b1;
        iord = 1'b1;
        if (ready) state_d = S_MWB;
      end
      S_MWB: begin
        rgw        = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_IF;
      end
      S_MW: begin
        mreq = 1'b1;
        mwe  = 1'b1;
        iord = 1'b1;
        if (ready) state_d = S_IF;
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        state_d   = funct_ok ? S_WBR : S_ERR;
      end
      S_WBR: begin
        rgw     = 1'b1;
        reg_dst = 1'b1;
        state_d = S_IF;
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_WBI;
      end
      S_WBI: begin
        rgw     = 1'b1;
        state_d = S_IF;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        pcw       = zero;
        state_d   = S_IF;
      end
      S_JMP: begin
        pc_src  = 2'b10;
        pcw     = 1'b1;
        state_d = S_IF;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // reset level blocks every request and write enable at once
  assign mem_req = mreq & rst;
  assign mem_we  = mwe & rst;
  assign ir_we   = irw & rst;
  assign pc_we   = pcw & rst;
  assign reg_we  = rgw & rst;
  assign state   = state_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit.
// Vector table plus per-cycle scoreboard and hand sequences.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal;

  logic       rst2;
  logic [5:0] op2;
  logic       mem_req2, mem_we2, iord2, ir_we2, pc_we2;
  logic       reg_we2, reg_dst2, mem_to_reg2, alu_src_a2;
  logic [1:0] alu_src_b2, pc_src2;
  logic [2:0] alu_op2;
  logic [3:0] state2;
  logic       illegal2;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .state(state), .illegal(illegal)
  );

  mc_control_unit #(.MEM_HANDSHAKE(0)) dut2 (
    .clk(clk), .rst(rst2), .opcode(op2), .funct(6'h00),
    .zero(1'b0), .mem_ready(1'b0), .mem_req(mem_req2),
    .mem_we(mem_we2), .iord(iord2), .ir_we(ir_we2), .pc_we(pc_we2),
    .reg_we(reg_we2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_src(pc_src2),
    .alu_op(alu_op2), .state(state2), .illegal(illegal2)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [31:0] seq;
    int          n;
    int          wat;
    int          nw;
    logic [3:0]  xst;
    logic [2:0]  alu;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [12:0] ctl;
    logic        achk;
    logic [2:0]  alu;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vt[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [5:0] op, input logic [5:0] fn, input logic z,
    input logic [31:0] seq, input int n, input int wat,
    input int nw, input logic [3:0] xst, input logic [2:0] alu);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.seq = seq; v.n = n;
    v.wat = wat; v.nw = nw; v.xst = xst; v.alu = alu;
    return v;
  endfunction

  function automatic logic [12:0] ctl_of(
    input logic [3:0] s, input logic rdy, input logic z);
    logic       mr, mw, io, irw, pcw, rw, rd, m2r, sa;
    logic [1:0] sb_, ps;
    mr  = (s == 0) || (s == 3) || (s == 5);
    mw  = (s == 5);
    io  = (s == 3) || (s == 5);
    irw = (s == 0) && rdy;
    pcw = ((s == 0) && rdy) || (s == 9) || ((s == 8) && z);
    rw  = (s == 4) || (s == 7) || (s == 11);
    rd  = (s == 7);
    m2r = (s == 4);
    ps  = (s == 8) ? 2'b01 : (s == 9) ? 2'b10 : 2'b00;
    sa  = (s == 2) || (s == 6) || (s == 8) || (s == 10);
    sb_ = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 :
          ((s == 2) || (s == 10)) ? 2'b10 : 2'b00;
    return {mr, mw, io, irw, pcw, rw, rd, m2r, ps, sa, sb_};
  endfunction

  function automatic logic [12:0] dut_ctl();
    return {mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst,
            mem_to_reg, pc_src, alu_src_a, alu_src_b};
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk("state", state, e.st);
    chk("ctl", dut_ctl(), e.ctl);
    if (e.achk) chk("alu_op", alu_op, e.alu);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t       e;
    logic [3:0] s;
    for (int i = 0; i < v.n; i++) begin
      opcode    = v.op;
      funct     = v.fn;
      zero      = v.z;
      mem_ready = !(i >= v.wat && i < v.wat + v.nw);
      s         = v.seq[31 - 4*i -: 4];
      e.st      = s;
      e.ctl     = ctl_of(s, mem_ready, v.z);
      e.achk    = (s == v.xst) || ((s == 7) && (v.xst == 6));
      e.alu     = v.alu;
      sb.push_back(e);
      #1;
      check_out();
      tick();
    end
  endtask

  initial begin
    vt[0]  = mk(6'h00, 6'h20, 0, 32'h0167_0000, 4, 0, 0, 6, ALU_ADD);
    vt[1]  = mk(6'h00, 6'h22, 0, 32'h0167_0000, 4, 0, 0, 6, ALU_SUB);
    vt[2]  = mk(6'h00, 6'h24, 0, 32'h0167_0000, 4, 0, 0, 6, ALU_AND);
    vt[3]  = mk(6'h00, 6'h25, 0, 32'h0167_0000, 4, 0, 0, 6, ALU_OR);
    vt[4]  = mk(6'h00, 6'h2A, 0, 32'h0167_0000, 4, 0, 0, 6, ALU_SLT);
    vt[5]  = mk(6'h23, 6'h00, 0, 32'h0123_4000, 5, 0, 0, 2, ALU_ADD);
    vt[6]  = mk(6'h23, 6'h00, 0, 32'h0123_3340, 7, 3, 2, 2, ALU_ADD);
    vt[7]  = mk(6'h2B, 6'h00, 0, 32'h0125_0000, 4, 0, 0, 2, ALU_ADD);
    vt[8]  = mk(6'h2B, 6'h00, 0, 32'h0125_5000, 5, 3, 1, 2, ALU_ADD);
    vt[9]  = mk(6'h08, 6'h00, 0, 32'h01AB_0000, 4, 0, 0, 10, ALU_ADD);
    vt[10] = mk(6'h0D, 6'h00, 0, 32'h01AB_0000, 4, 0, 0, 10, ALU_OR);
    vt[11] = mk(6'h04, 6'h00, 1, 32'h0180_0000, 3, 0, 0, 8, ALU_SUB);
    vt[12] = mk(6'h04, 6'h00, 0, 32'h0180_0000, 3, 0, 0, 8, ALU_SUB);
    vt[13] = mk(6'h02, 6'h00, 0, 32'h0190_0000, 3, 0, 0, 9, ALU_AND);
    vt[14] = mk(6'h00, 6'h20, 0, 32'h0001_6700, 6, 0, 2, 6, ALU_ADD);

    rst = 1'b0; rst2 = 1'b0; op2 = OP_SW;
    opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_pc_we", pc_we, 0);
    rst = 1'b1;

    foreach (vt[k]) run_vec(vt[k]);
    chk("idle_state", state, 0);

    opcode = 6'h3F; mem_ready = 1'b1;
    #1 chk("ill_if", state, 0);
    tick(); chk("ill_id", state, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("err_state", state, 15);
      chk("err_illegal", illegal, 1);
      chk("err_wen", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
      tick();
    end
    rst = 1'b0;
    #1 chk("err_rst_state", state, 0);
    chk("err_rst_illegal", illegal, 0);
    tick(); rst = 1'b1;

    opcode = 6'h00; funct = 6'h3F;
    #1 chk("badfn_if", state, 0);
    tick(); chk("badfn_id", state, 1);
    tick(); chk("badfn_exr", state, 6);
    chk("badfn_ill0", illegal, 0);
    tick(); chk("badfn_err", state, 15);
    chk("badfn_ill1", illegal, 1);
    rst = 1'b0;
    tick(); rst = 1'b1;

    opcode = OP_SW; funct = '0; mem_ready = 1'b1;
    #1 chk("mw_if", state, 0);
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1 chk("mw_state", state, 5);
    chk("mw_req", {mem_req, mem_we, iord}, 3'b111);
    tick();
    chk("mw_hold", {mem_req, mem_we, iord, 1'(state == 5)}, 4'hF);
    rst = 1'b0;
    #1 chk("mw_rst_drop", {mem_req, mem_we}, 0);
    chk("mw_rst_state", state, 0);
    tick(); rst = 1'b1;
    #1 chk("refetch_wait", {ir_we, mem_req}, 2'b01);
    tick(); chk("refetch_hold", state, 0);
    mem_ready = 1'b1;
    #1 chk("refetch_irwe", ir_we, 1);
    tick(); chk("refetch_id", state, 1);

    rst2 = 1'b1;
    #1 chk("nh_if", state2, 0);
    tick(); chk("nh_id", state2, 1);
    tick(); chk("nh_ma", state2, 2);
    tick(); chk("nh_mw", state2, 5);
    chk("nh_mw_we", {mem_req2, mem_we2}, 2'b11);
    tick(); chk("nh_done", state2, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
